mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one 4:1 select datapath between four requesters.

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/arb_data_mux.sv | 16 +
 rtl/mux_rr_arbiter.sv | 113 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick helper for mux_rr_arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    // First set bit of req searching ptr+1, ptr+2, ... with wrap; ptr itself is checked last.
    function automatic sel_t rr_pick(input logic [N_REQ-1:0] req, input sel_t ptr);
        sel_t idx;
        sel_t pick;
        pick = ptr;
        for (int unsigned i = N_REQ; i >= 1; i--) begin
            idx = ptr + sel_t'(i);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_data_mux.sv
// 4:1 data select: forwards the DATA_W slice of data_i chosen by sel_i.
module arb_data_mux
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]              sel_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [DATA_W-1:0]       data_o
);

    always_comb begin
        data_o = data_i[int'(sel_i)*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select datapath; valid/ready output, no bubble.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    input  logic [N_REQ-1:0]        lock_i,
    input  logic                    out_ready_i,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [1:0]              sel_o,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    busy_o
);

    arb_state_t       state_q, state_d;
    sel_t             sel_q, sel_d;
    sel_t             ptr_q, ptr_d;
    logic [N_REQ-1:0] masked_req;
    logic             keep;

`ifdef ARB_LOCK_EN
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`else
    logic             unused_lock;
    localparam int    unused_max_lock = MAX_LOCK;
    assign unused_lock = ^lock_i;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        ack_o      = '0;
        keep       = 1'b0;
        masked_req = req_i;
        masked_req[sel_q] = 1'b0;
`ifdef ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    sel_d   = rr_pick(req_i, ptr_q);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    ack_o[sel_q] = 1'b1;
`ifdef ARB_LOCK_EN
                    if (lock_i[sel_q] && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
                        keep       = 1'b1;
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end else begin
                        lock_cnt_d = '0;
                    end
`endif
                    // Re-arbitrate in the accept cycle so the next beat follows without a bubble.
                    if (!keep) begin
                        ptr_d = sel_q;
                        if (|masked_req) begin
                            sel_d = rr_pick(masked_req, sel_q);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= sel_t'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    assign out_valid_o = (state_q == HOLD);
    assign busy_o      = (state_q != IDLE);
    assign sel_o       = sel_q;

    arb_data_mux #(.DATA_W(DATA_W)) u_data_mux (
        .sel_i  (sel_q),
        .data_i (data_i),
        .data_o (out_data_o)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter (default build or ARB_LOCK_EN).
module tb_mux_rr_arbiter;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          req_i;
    logic [4*DATA_W-1:0] data_i;
    logic [3:0]          lock_i;
    logic                out_ready_i;
    logic                out_valid_o;
    logic [DATA_W-1:0]   out_data_o;
    logic [1:0]          sel_o;
    logic [3:0]          ack_o;
    logic                busy_o;

    logic [7:0] port_data [4];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic       ev;
        logic [1:0] es;
        logic [3:0] ea;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(DATA_W), .MAX_LOCK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .data_i      (data_i),
        .lock_i      (lock_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .sel_o       (sel_o),
        .ack_o       (ack_o),
        .busy_o      (busy_o)
    );

    a_req_held: assert property (@(posedge clk) disable iff (!rst_n) out_valid_o |-> req_i[sel_o])
        else $error("selected requester dropped req_i while out_valid_o high");
    a_ack_ok: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ack_o) && ((ack_o == 4'b0) || out_valid_o))
        else $error("ack_o not one-hot or asserted without out_valid_o");

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic rdy, input logic ev, input logic [1:0] es, input logic [3:0] ea);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.rdy = rdy;
        v.ev = ev; v.es = es; v.ea = ea;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic ev, input logic [1:0] es, input logic [3:0] ea);
        n_vec++;
        if (out_valid_o !== ev) begin
            n_err++;
            $display("FAIL %s valid got %b want %b", name, out_valid_o, ev);
        end
        if (busy_o !== ev) begin
            n_err++;
            $display("FAIL %s busy got %b want %b", name, busy_o, ev);
        end
        if (sel_o !== es) begin
            n_err++;
            $display("FAIL %s sel got %0d want %0d", name, sel_o, es);
        end
        if (ack_o !== ea) begin
            n_err++;
            $display("FAIL %s ack got %b want %b", name, ack_o, ea);
        end
        if (out_data_o !== port_data[es]) begin
            n_err++;
            $display("FAIL %s data got %h want %h", name, out_data_o, port_data[es]);
        end
    endtask

    initial begin
        port_data[0] = 8'h10;
        port_data[1] = 8'h21;
        port_data[2] = 8'hA5;
        port_data[3] = 8'h43;
        data_i      = {port_data[3], port_data[2], port_data[1], port_data[0]};
        rst_n       = 1'b0;
        req_i       = '0;
        lock_i      = '0;
        out_ready_i = 1'b0;

        //   rst   req      lock     rdy   ev    sel    ack
        // Reset state, then single requester on port 2
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100);
        add(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
        // Port 1 stalled by ready low for three cycles
        add(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000);
        add(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
        add(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
        add(1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
        add(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000);
        // All four requesting: 0,1,2,3,0,1 back to back
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001);
        add(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100);
        add(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000);
        add(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001);
        add(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000);
        // Wrap from ptr=3: port 0 then port 3
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b1, 4'b1001, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001);
        add(1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000);
        add(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000);
        // Lock request on port 1 with port 2 competing
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b0, 2'd3, 4'b0000);
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010);
`ifdef ARB_LOCK_EN
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd2, 4'b0100);
`else
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd2, 4'b0100);
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd2, 4'b0100);
        add(1'b1, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010);
`endif
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n       = vq[i].rst;
            req_i       = vq[i].req;
            lock_i      = vq[i].lock;
            out_ready_i = vq[i].rdy;
            #1;
            check($sformatf("vec%0d", i), vq[i].ev, vq[i].es, vq[i].ea);
        end

        // Asynchronous reset in the middle of an accept-pending HOLD cycle
        @(negedge clk);
        rst_n = 1'b1; req_i = 4'b0100; lock_i = '0; out_ready_i = 1'b0;
        #1 check("ar_idle", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        out_ready_i = 1'b1;
        #1 check("ar_hold", 1'b1, 2'd2, 4'b0100);
        #2 rst_n = 1'b0;
        #1 check("ar_async", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1; req_i = 4'b1010; out_ready_i = 1'b1;
        #1 check("ar_rel", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        #1 check("ar_p1", 1'b1, 2'd1, 4'b0010);
        @(negedge clk);
        req_i = 4'b1000;
        #1 check("ar_p3", 1'b1, 2'd3, 4'b1000);
        @(negedge clk);
        req_i = 4'b0000;
        #1 check("ar_end", 1'b0, 2'd3, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
